// File: rtl/execute_stage_if.sv
// Instruction issue, register file read and write-back bundle for execute_stage.
// Signal names match the original flat port list so existing hookups map one-to-one.
interface execute_stage_if;
    logic        IVALID;
    logic        IREADY;
    logic [3:0]  OPCODE;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [4:0]  RD;
    logic [15:0] IMM;
    logic        USEIMM;
    logic [4:0]  ASEL;
    logic [4:0]  BSEL;
    logic [31:0] AOUT;
    logic [31:0] BOUT;
    logic        WR;
    logic [4:0]  DSEL;
    logic [31:0] DIN;
    logic        BUSY;

    modport master (
        output IVALID, OPCODE, RS1, RS2, RD, IMM, USEIMM, AOUT, BOUT,
        input  IREADY, ASEL, BSEL, WR, DSEL, DIN, BUSY
    );

    modport slave (
        input  IVALID, OPCODE, RS1, RS2, RD, IMM, USEIMM, AOUT, BOUT,
        output IREADY, ASEL, BSEL, WR, DSEL, DIN, BUSY
    );
endinterface

// File: rtl/execute_stage.sv
// Single-issue execute/write-back stage: forwarding operand capture, 32-bit ALU with
// a multi-cycle multiply, and a registered write-back port into the register file.
module execute_stage #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic           clock,
    input  logic           reset,
    execute_stage_if.slave bus
);
    localparam int unsigned   CW       = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SINGLE, MUL_RUN, DONE} ex_state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU, OP_MUL, OP_PASSB
    } opcode_t;

    ex_state_t     state;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [3:0]    ex_op;
    logic [4:0]    ex_rd;
    logic          ex_wr;
    logic [31:0]   ex_a;
    logic [31:0]   ex_b;
    logic          wr_q;
    logic [4:0]    dsel_q;
    logic [31:0]   din_q;

    logic [31:0]   ex_result;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic          ready;
    logic          accept;
    logic          ex_live;

    assign ready    = reset & ~busy;
    assign accept   = bus.IVALID & ready;
    // EX result is final (and forwardable) only for a single-cycle op or a finished MUL
    assign ex_live  = ((state == SINGLE) || (state == DONE)) && ex_wr;

    assign bus.IREADY = ready;
    assign bus.BUSY   = busy;
    assign bus.ASEL   = bus.RS1;
    assign bus.BSEL   = bus.RS2;
    assign bus.WR     = wr_q;
    assign bus.DSEL   = dsel_q;
    assign bus.DIN    = din_q;

    always_comb begin
        ex_result = '0;
        case (ex_op)
            OP_ADD:   ex_result = ex_a + ex_b;
            OP_SUB:   ex_result = ex_a - ex_b;
            OP_AND:   ex_result = ex_a & ex_b;
            OP_OR:    ex_result = ex_a | ex_b;
            OP_XOR:   ex_result = ex_a ^ ex_b;
            OP_SLL:   ex_result = ex_a << ex_b[4:0];
            OP_SRL:   ex_result = ex_a >> ex_b[4:0];
            OP_SRA:   ex_result = 32'($signed(ex_a) >>> ex_b[4:0]);
            OP_SLT:   ex_result = {31'b0, $signed(ex_a) < $signed(ex_b)};
            OP_SLTU:  ex_result = {31'b0, ex_a < ex_b};
            OP_MUL:   ex_result = ex_a * ex_b;
            OP_PASSB: ex_result = ex_b;
            default:  ex_result = '0;
        endcase
    end

    // Youngest producer wins; r0 always reads the register file
    always_comb begin
        op_a = bus.AOUT;
        if (bus.RS1 != '0) begin
            if (ex_live && ex_rd == bus.RS1)
                op_a = ex_result;
            else if (wr_q && dsel_q == bus.RS1)
                op_a = din_q;
        end
        op_b = bus.BOUT;
        if (bus.USEIMM)
            op_b = {{16{bus.IMM[15]}}, bus.IMM};
        else if (bus.RS2 != '0) begin
            if (ex_live && ex_rd == bus.RS2)
                op_b = ex_result;
            else if (wr_q && dsel_q == bus.RS2)
                op_b = din_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            ex_op  <= '0;
            ex_rd  <= '0;
            ex_wr  <= 1'b0;
            ex_a   <= '0;
            ex_b   <= '0;
            wr_q   <= 1'b0;
            dsel_q <= '0;
            din_q  <= '0;
        end else begin
            wr_q <= ex_live;
            if (ex_live) begin
                dsel_q <= ex_rd;
                din_q  <= ex_result;
            end
            if (state == MUL_RUN) begin
                if (cnt == CNT_LAST) begin
                    state <= DONE;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (accept) begin
                ex_op <= bus.OPCODE;
                ex_rd <= bus.RD;
                ex_wr <= (bus.OPCODE <= OP_PASSB) && (bus.RD != '0);
                ex_a  <= op_a;
                ex_b  <= op_b;
                if (bus.OPCODE == OP_MUL) begin
                    state <= MUL_RUN;
                    cnt   <= CW'(1);
                    busy  <= 1'b1;
                end else begin
                    state <= SINGLE;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: architectural register model plus latency schedule,
// directed vector table, hand-written multi-cycle sequences and random traffic.
module tb_execute_stage;
    localparam int MC = 4;

    logic clock;
    logic reset;
    logic load_regs;
    logic [31:0] regs [32];
    logic [31:0] seed_vals [32];

    execute_stage_if bif();

    execute_stage #(.MUL_CYCLES(MC)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bif)
    );

    assign bif.AOUT = regs[bif.ASEL];
    assign bif.BOUT = regs[bif.BSEL];

    always @(posedge clock) begin
        if (load_regs) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 0) ? 32'd0 : seed_vals[i];
        end else if (bif.WR === 1'b1 && bif.DSEL != 5'd0) begin
            regs[bif.DSEL] <= bif.DIN;
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [4:0]  dsel;
        logic [31:0] din;
        int          edge_i;
    } wrec_t;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        useimm;
        logic        exp_wr;
        logic [31:0] exp_din;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          edges   = 0;
    int          busy_end = -1;
    int          busy_seen = 0;
    bit          acc_flag;
    bit          resync;
    logic [31:0] arch [32];
    exp_t        expq [$];
    wrec_t       wlog [$];
    vec_t        vt [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%08h, expected 0x%08h", name, edges, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] wide;
        int unsigned sh;
        sh = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7: begin
                wide = {{32{a[31]}}, a} >> sh;
                return wide[31:0];
            end
            4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                wide = 64'(a) * 64'(b);
                return wide[31:0];
            end
            4'd11: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Called right after each rising edge: decides acceptance and schedules write-back
    task automatic model_edge();
        logic        was_busy;
        logic [31:0] a, b, res;
        int          lat;
        was_busy = (edges <= busy_end);
        acc_flag = reset && bif.IVALID && !was_busy;
        edges++;
        if (!reset) begin
            expq.delete();
            busy_end = -1;
            resync = 1;
        end else if (acc_flag) begin
            a   = arch[bif.RS1];
            b   = bif.USEIMM ? {{16{bif.IMM[15]}}, bif.IMM} : arch[bif.RS2];
            res = ref_alu(bif.OPCODE, a, b);
            lat = (bif.OPCODE == 4'd10) ? MC : 1;
            if (bif.OPCODE <= 4'd11 && bif.RD != 5'd0) begin
                arch[bif.RD] = res;
                expq.push_back('{edges + lat, bif.RD, res});
            end
            if (bif.OPCODE == 4'd10)
                busy_end = edges + MC - 2;
        end
    endtask

    task automatic model_check();
        logic exp_wr, exp_busy;
        if (resync) begin
            for (int i = 0; i < 32; i++) arch[i] = regs[i];
            resync = 0;
        end
        exp_wr   = (expq.size() > 0) && (expq[0].due == edges);
        exp_busy = (edges <= busy_end);
        chk("wr", bif.WR, exp_wr);
        if (exp_wr) begin
            chk("dsel", bif.DSEL, expq[0].rd);
            chk("din", bif.DIN, expq[0].val);
            void'(expq.pop_front());
        end
        chk("busy", bif.BUSY, exp_busy);
        chk("iready", bif.IREADY, reset && !exp_busy);
        chk("asel", bif.ASEL, bif.RS1);
        chk("bsel", bif.BSEL, bif.RS2);
        if (bif.WR === 1'b1) wlog.push_back('{bif.DSEL, bif.DIN, edges});
        if (bif.BUSY === 1'b1) busy_seen++;
    endtask

    task automatic cyc_step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        model_check();
    endtask

    task automatic idle(input int n);
        bif.IVALID = 1'b0;
        repeat (n) cyc_step();
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [15:0] imm, input logic useimm);
        bif.IVALID = 1'b1;
        bif.OPCODE = op;
        bif.RS1    = rs1;
        bif.RS2    = rs2;
        bif.RD     = rd;
        bif.IMM    = imm;
        bif.USEIMM = useimm;
        acc_flag   = 0;
        for (int k = 0; k < 20 && !acc_flag; k++) cyc_step();
        chk("accept", acc_flag, 1);
        bif.IVALID = 1'b0;
    endtask

    task automatic chk_wlog(input int idx, input logic [4:0] dsel, input logic [31:0] din);
        if (idx < wlog.size()) begin
            chk("wlog_dsel", wlog[idx].dsel, dsel);
            chk("wlog_din", wlog[idx].din, din);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL wlog_missing: entry %0d absent, only %0d writes seen", idx, wlog.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_edge, add_edge, n0;

        for (int i = 0; i < 32; i++) seed_vals[i] = $urandom;
        bif.IVALID = 1'b0; bif.OPCODE = '0; bif.RS1 = '0; bif.RS2 = '0;
        bif.RD = '0; bif.IMM = '0; bif.USEIMM = 1'b0;

        // Reset held 3 cycles with an instruction offered: must be ignored
        reset = 1'b0;
        load_regs = 1'b1;
        bif.IVALID = 1'b1; bif.OPCODE = 4'd0; bif.RS1 = 5'd1; bif.RS2 = 5'd2; bif.RD = 5'd25;
        repeat (3) begin
            cyc_step();
            chk("rst_dsel", bif.DSEL, 5'd0);
            chk("rst_din", bif.DIN, 32'd0);
        end
        bif.IVALID = 1'b0;
        load_regs = 1'b0;
        reset = 1'b1;
        cyc_step();
        chk("iready_release", bif.IREADY, 1'b1);
        idle(3);
        chk("rst_no_write", wlog.size(), 0);

        // Back-to-back immediates
        wlog.delete();
        issue(4'd11, 5'd0, 5'd0, 5'd5, 16'h0007, 1'b1);
        issue(4'd11, 5'd0, 5'd0, 5'd9, 16'hFFFF, 1'b1);
        idle(4);
        chk("imm_count", wlog.size(), 2);
        chk_wlog(0, 5'd5, 32'h0000_0007);
        chk_wlog(1, 5'd9, 32'hFFFF_FFFF);

        // Dependent chain: EX forward then WB forward, no stall
        wlog.delete();
        issue(4'd0, 5'd5, 5'd9, 5'd1, 16'h0, 1'b0);
        issue(4'd1, 5'd1, 5'd5, 5'd2, 16'h0, 1'b0);
        issue(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        idle(4);
        chk("fwd_count", wlog.size(), 3);
        chk_wlog(0, 5'd1, 32'h0000_0006);
        chk_wlog(1, 5'd2, 32'hFFFF_FFFF);
        chk_wlog(2, 5'd3, 32'hFFFF_FFF9);
        if (wlog.size() == 3)
            chk("fwd_spacing", 32'(wlog[2].edge_i - wlog[0].edge_i), 32'd2);

        // Vector table, one instruction at a time
        vt.push_back('{4'd11, 5'd0,  5'd0, 5'd5,  16'h0007, 1'b1, 1'b1, 32'h0000_0007});
        vt.push_back('{4'd11, 5'd0,  5'd0, 5'd9,  16'hFFFF, 1'b1, 1'b1, 32'hFFFF_FFFF});
        vt.push_back('{4'd11, 5'd0,  5'd0, 5'd10, 16'h0001, 1'b1, 1'b1, 32'h0000_0001});
        vt.push_back('{4'd5,  5'd10, 5'd0, 5'd11, 16'd31,   1'b1, 1'b1, 32'h8000_0000});
        vt.push_back('{4'd7,  5'd11, 5'd0, 5'd12, 16'd4,    1'b1, 1'b1, 32'hF800_0000});
        vt.push_back('{4'd6,  5'd11, 5'd0, 5'd13, 16'd4,    1'b1, 1'b1, 32'h0800_0000});
        vt.push_back('{4'd8,  5'd9,  5'd0, 5'd14, 16'd1,    1'b1, 1'b1, 32'h0000_0001});
        vt.push_back('{4'd9,  5'd9,  5'd0, 5'd15, 16'd1,    1'b1, 1'b1, 32'h0000_0000});
        vt.push_back('{4'd8,  5'd5,  5'd0, 5'd26, 16'hFFFF, 1'b1, 1'b1, 32'h0000_0000});
        vt.push_back('{4'd9,  5'd5,  5'd0, 5'd27, 16'hFFFF, 1'b1, 1'b1, 32'h0000_0001});
        vt.push_back('{4'd0,  5'd5,  5'd9, 5'd16, 16'h0,    1'b0, 1'b1, 32'h0000_0006});
        vt.push_back('{4'd1,  5'd5,  5'd0, 5'd17, 16'd8,    1'b1, 1'b1, 32'hFFFF_FFFF});
        vt.push_back('{4'd2,  5'd9,  5'd0, 5'd18, 16'h00F0, 1'b1, 1'b1, 32'h0000_00F0});
        vt.push_back('{4'd3,  5'd5,  5'd0, 5'd19, 16'h0100, 1'b1, 1'b1, 32'h0000_0107});
        vt.push_back('{4'd4,  5'd9,  5'd0, 5'd20, 16'h0F0F, 1'b1, 1'b1, 32'hFFFF_F0F0});
        vt.push_back('{4'd10, 5'd5,  5'd0, 5'd21, 16'd3,    1'b1, 1'b1, 32'h0000_0015});
        vt.push_back('{4'd11, 5'd0,  5'd0, 5'd0,  16'd5,    1'b1, 1'b0, 32'h0000_0000});
        vt.push_back('{4'd13, 5'd5,  5'd9, 5'd7,  16'h0,    1'b0, 1'b0, 32'h0000_0000});
        vt.push_back('{4'd0,  5'd5,  5'd5, 5'd22, 16'h0,    1'b0, 1'b1, 32'h0000_000E});
        foreach (vt[i]) begin
            wlog.delete();
            issue(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].imm, vt[i].useimm);
            idle(MC + 3);
            chk($sformatf("vec%0d_wrcount", i), wlog.size(), vt[i].exp_wr ? 1 : 0);
            if (vt[i].exp_wr) chk_wlog(0, vt[i].rd, vt[i].exp_din);
        end

        // MUL with a dependent ADD held upstream while BUSY
        issue(4'd11, 5'd0, 5'd0, 5'd6, 16'h0001, 1'b1);
        issue(4'd5,  5'd6, 5'd0, 5'd7, 16'd16,   1'b1);
        issue(4'd3,  5'd7, 5'd0, 5'd8, 16'h0001, 1'b1);
        idle(3);
        wlog.delete();
        busy_seen = 0;
        issue(4'd10, 5'd8, 5'd8, 5'd4, 16'h0, 1'b0);
        acc_edge = edges;
        issue(4'd0, 5'd4, 5'd5, 5'd24, 16'h0, 1'b0);
        add_edge = edges;
        idle(5);
        chk("mul_busy_cycles", busy_seen, MC - 1);
        chk("mul_next_accept", 32'(add_edge - acc_edge), MC);
        chk("mul_count", wlog.size(), 2);
        chk_wlog(0, 5'd4, 32'h0002_0001);
        chk_wlog(1, 5'd24, 32'h0002_0008);
        if (wlog.size() == 2) begin
            chk("mul_wr_lat", 32'(wlog[0].edge_i - acc_edge), MC);
            chk("add_wr_lat", 32'(wlog[1].edge_i - acc_edge), MC + 1);
        end

        // Reset two edges into a MUL: its result must never be written
        issue(4'd11, 5'd0, 5'd0, 5'd23, 16'h1234, 1'b1);
        idle(3);
        wlog.delete();
        issue(4'd10, 5'd5, 5'd5, 5'd23, 16'h0, 1'b0);
        idle(1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(8);
        chk("midmul_no_write", wlog.size(), 0);
        chk("midmul_reg", regs[23], 32'h0000_1234);

        // Random traffic against the architectural model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b0;
                idle(1);
                reset = 1'b1;
            end
            issue(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(MC + 3);
        chk("drain_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
